// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Downstream stage of the carry-ripple ALU. It captures each ALU result
// (Y, 16-bit flags word, 4-bit op select) in a 2-entry skid queue. The queue
// has valid/ready handshakes on both sides. The stage also maintains the
// architectural processor status register (PSR) and evaluates branch
// conditions against it.
//
// The queue is built from two registers. The head register drives out_* and
// the skid register holds the second entry while the head is stalled.
//
// Parameters
//   BITSIZE  datapath width; must match the ALU
//   DEPTH    queue entries; only 2 is supported
//   CNTW     width of the accepted-op counter
//
// Ports
//   clk, rst_n             clock (rising edge) / asynchronous active-low reset
//   in_valid, in_ready     producer handshake; in_ready is registered
//   in_y, in_flags, in_sel ALU result, flags word (C=0 L=2 F=5 Z=6 N=7), op sel
//   out_valid, out_ready   consumer handshake on the head entry
//   out_y, out_flags,      head entry; flags are passed through unmodified
//   out_sel
//   psr_wr, psr_din        explicit PSR load; takes priority over a push
//   psr                    current PSR (bits 1, 3, 4, 15:8 always 0)
//   cond_sel, cond_true    condition code select / result on current PSR
//   op_count               saturating count of accepted ops
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int BITSIZE = 16,
    parameter int DEPTH   = 2,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] in_y,
    input  logic [15:0]        in_flags,
    input  logic [3:0]         in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] out_y,
    output logic [15:0]        out_flags,
    output logic [3:0]         out_sel,
    input  logic               psr_wr,
    input  logic [15:0]        psr_din,
    output logic [15:0]        psr,
    input  logic [2:0]         cond_sel,
    output logic               cond_true,
    output logic [CNTW-1:0]    op_count
);

    localparam logic [1:0]      FULL       = DEPTH[1:0];
    localparam logic [15:0]     PSR_MASK   = 16'h00E5;  // C, L, F, Z, N
    localparam logic [15:0]     ARITH_MASK = 16'h00E5;  // add/sub update every flag
    localparam logic [15:0]     LOGIC_MASK = 16'h00C0;  // logic ops update Z, N only
    localparam logic [CNTW-1:0] CNT_ONE    = 1;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // PSR value after a push of an op with the given sel and flags.
    function automatic logic [15:0] f_psr_update(
        input logic [15:0] cur,
        input logic [15:0] flags,
        input logic [3:0]  sel
    );
        logic [15:0] res;
        res = cur;
        casez (sel)
            4'b010?: res = (cur & ~ARITH_MASK) | (flags & ARITH_MASK);
            4'b1???: res = (cur & ~LOGIC_MASK) | (flags & LOGIC_MASK);
            default: res = cur;
        endcase
        return res & PSR_MASK;
    endfunction

    function automatic logic f_cond_eval(
        input logic [15:0] p,
        input logic [2:0]  sel
    );
        logic res;
        case (sel)
            3'd0:    res = 1'b1;
            3'd1:    res = p[PSR_Z];
            3'd2:    res = !p[PSR_Z];
            3'd3:    res = p[PSR_N];
            3'd4:    res = p[PSR_C];
            3'd5:    res = p[PSR_L];
            3'd6:    res = p[PSR_F];
            default: res = !p[PSR_N] && !p[PSR_Z];
        endcase
        return res;
    endfunction

    logic [1:0]         r_count;
    logic               r_in_ready;
    logic [BITSIZE-1:0] r_head_y;
    logic [15:0]        r_head_flags;
    logic [3:0]         r_head_sel;
    logic [BITSIZE-1:0] r_skid_y;
    logic [15:0]        r_skid_flags;
    logic [3:0]         r_skid_sel;
    logic [15:0]        r_psr;
    logic [CNTW-1:0]    r_op_count;

    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_count_next;
    logic               w_load_head_in;
    logic               w_load_head_skid;
    logic               w_load_skid;
    logic [15:0]        w_psr_next;
    logic [CNTW-1:0]    w_op_count_next;

    // ---- handshake decode --------------------------------------------------
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // The head takes the incoming entry when the queue is empty, or when the
    // only entry leaves in the same cycle. It takes the skid entry when the
    // queue drains from full. A push is never accepted at full, so these
    // cases cover every head change.
    assign w_load_head_in   = w_push && ((r_count == 2'd0) ||
                                         ((r_count == 2'd1) && w_pop));
    assign w_load_head_skid = w_pop && (r_count == 2'd2);
    assign w_load_skid      = w_push && (r_count == 2'd1) && !w_pop;

    always_comb begin
        w_psr_next = r_psr;
        if (psr_wr) begin
            w_psr_next = psr_din & PSR_MASK;
        end else if (w_push) begin
            w_psr_next = f_psr_update(r_psr, in_flags, in_sel);
        end
    end

    assign w_op_count_next = (&r_op_count) ? r_op_count : r_op_count + CNT_ONE;

    // ---- registered state --------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_psr      <= 16'h0000;
            r_op_count <= '0;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < FULL);
            r_psr      <= w_psr_next;
            if (w_push) begin
                r_op_count <= w_op_count_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_y     <= '0;
            r_head_flags <= 16'h0000;
            r_head_sel   <= 4'h0;
        end else if (w_load_head_in) begin
            r_head_y     <= in_y;
            r_head_flags <= in_flags;
            r_head_sel   <= in_sel;
        end else if (w_load_head_skid) begin
            r_head_y     <= r_skid_y;
            r_head_flags <= r_skid_flags;
            r_head_sel   <= r_skid_sel;
        end
    end

    // Skid storage is only read after being written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_y     <= in_y;
            r_skid_flags <= in_flags;
            r_skid_sel   <= in_sel;
        end
    end

    // ---- outputs -----------------------------------------------------------
    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_y     = r_head_y;
    assign out_flags = r_head_flags;
    assign out_sel   = r_head_sel;
    assign psr       = r_psr;
    assign cond_true = f_cond_eval(r_psr, cond_sel);
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int BITSIZE = 16;
    localparam int CNTW    = 6;   // small so saturation is reached quickly

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [BITSIZE-1:0] in_y;
    logic [15:0]        in_flags;
    logic [3:0]         in_sel;
    logic               out_valid;
    logic               out_ready;
    logic [BITSIZE-1:0] out_y;
    logic [15:0]        out_flags;
    logic [3:0]         out_sel;
    logic               psr_wr;
    logic [15:0]        psr_din;
    logic [15:0]        psr;
    logic [2:0]         cond_sel;
    logic               cond_true;
    logic [CNTW-1:0]    op_count;

    alu_result_stage #(.BITSIZE(BITSIZE), .DEPTH(2), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_flags  (in_flags),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .out_sel   (out_sel),
        .psr_wr    (psr_wr),
        .psr_din   (psr_din),
        .psr       (psr),
        .cond_sel  (cond_sel),
        .cond_true (cond_true),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] fl;
        logic [3:0]  sel;
    } ent_t;

    // reference model state
    ent_t        q[$];
    ent_t        m_last;
    logic [15:0] m_psr;
    logic        m_rdy;
    int          m_opc;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] psr_after_op(input logic [15:0] p, input ent_t e);
        logic [15:0] r;
        r = p;
        if (e.sel == 4'd4 || e.sel == 4'd5) begin
            r[0] = e.fl[0];
            r[2] = e.fl[2];
            r[5] = e.fl[5];
            r[6] = e.fl[6];
            r[7] = e.fl[7];
        end else if (e.sel >= 4'd8) begin
            r[6] = e.fl[6];
            r[7] = e.fl[7];
        end
        return r;
    endfunction

    function automatic logic [15:0] psr_load(input logic [15:0] d);
        logic [15:0] r;
        r = 16'h0000;
        r[0] = d[0];
        r[2] = d[2];
        r[5] = d[5];
        r[6] = d[6];
        r[7] = d[7];
        return r;
    endfunction

    function automatic logic cond_ref(input logic [15:0] p, input logic [2:0] cs);
        logic c, l, f, z, n;
        c = p[0]; l = p[2]; f = p[5]; z = p[6]; n = p[7];
        case (cs)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return c;
            3'd5: return l;
            3'd6: return f;
            default: return !n && !z;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_psr  = 16'h0000;
        m_rdy  = 1'b1;
        m_opc  = 0;
    endtask

    task automatic check_all();
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
        chk("out_y",     {16'd0, out_y},     {16'd0, m_last.y});
        chk("out_flags", {16'd0, out_flags}, {16'd0, m_last.fl});
        chk("out_sel",   {28'd0, out_sel},   {28'd0, m_last.sel});
        chk("psr",       {16'd0, psr},       {16'd0, m_psr});
        chk("cond_true", {31'd0, cond_true}, {31'd0, cond_ref(m_psr, cond_sel)});
        chk("op_count",  {26'd0, op_count},  m_opc);
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic iv, input logic [15:0] y, input logic [15:0] fl,
                        input logic [3:0] sel, input logic ordy, input logic pw,
                        input logic [15:0] pd, input logic [2:0] cs);
        ent_t e;
        logic push, pop;
        in_valid = iv; in_y = y; in_flags = fl; in_sel = sel;
        out_ready = ordy; psr_wr = pw; psr_din = pd; cond_sel = cs;
        e.y = y; e.fl = fl; e.sel = sel;
        push = iv && m_rdy;
        pop  = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        if (q.size() != 0) m_last = q[0];
        m_rdy = (q.size() < 2);
        if (pw)        m_psr = psr_load(pd);
        else if (push) m_psr = psr_after_op(m_psr, e);
        if (push && m_opc < (1 << CNTW) - 1) m_opc++;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_y = '0; in_flags = '0; in_sel = '0;
        out_ready = 1'b0; psr_wr = 1'b0; psr_din = '0; cond_sel = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // first push: arithmetic op, 1-cycle latency
        step(1'b1, 16'h8000, 16'h00A0, 4'h4, 1'b1, 1'b0, 16'h0, 3'd6);
        chk("first_out_y", {16'd0, out_y}, 32'h8000);
        chk("first_psr",   {16'd0, psr},   32'h00A0);
        chk("first_cond",  {31'd0, cond_true}, 32'd1);
        chk("first_opc",   {26'd0, op_count},  32'd1);
        step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h0, 3'd0);

        // fill with consumer stalled, third offer refused
        step(1'b1, 16'h1111, 16'h0001, 4'h0, 1'b0, 1'b0, 16'h0, 3'd2);
        step(1'b1, 16'h2222, 16'h0002, 4'h1, 1'b0, 1'b0, 16'h0, 3'd3);
        chk("full_rdy", {31'd0, in_ready}, 32'd0);
        step(1'b1, 16'h3333, 16'h0003, 4'h2, 1'b0, 1'b0, 16'h0, 3'd4);
        chk("full_head", {16'd0, out_y}, 32'h1111);
        step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h0, 3'd0);
        chk("pop_full_rdy", {31'd0, in_ready}, 32'd1);
        chk("second_head",  {16'd0, out_y},    32'h2222);
        step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h0, 3'd0);

        // logic op keeps C/L/F, takes Z/N
        step(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1, 16'h0025, 3'd5);
        step(1'b1, 16'h00AA, 16'h0041, 4'h8, 1'b0, 1'b0, 16'h0, 3'd1);
        chk("logic_psr",  {16'd0, psr},       32'h0065);
        chk("logic_cond", {31'd0, cond_true}, 32'd1);
        step(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h0, 3'd0);

        // psr_wr beats a simultaneous push; push still enqueues
        step(1'b1, 16'h5A5A, 16'h0000, 4'h4, 1'b0, 1'b1, 16'hFFFF, 3'd7);
        chk("wr_psr",   {16'd0, psr},       32'h00E5);
        chk("wr_valid", {31'd0, out_valid}, 32'd1);
        chk("wr_y",     {16'd0, out_y},     32'h5A5A);

        // streaming at count=1
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 1'b1, 1'b0, 16'h0,
                 3'($urandom));
            chk("stream_rdy", {31'd0, in_ready}, 32'd1);
        end

        // reach full with psr=0x0040, then asynchronous reset mid-cycle
        step(1'b1, 16'h7777, 16'h00FF, 4'h4, 1'b0, 1'b1, 16'h0040, 3'd1);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_psr",   {16'd0, psr},       32'd0);
        chk("rst_rdy",   {31'd0, in_ready},  32'd1);
        chk("rst_opc",   {26'd0, op_count},  32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 3'd0);

        // randomized traffic (also drives op_count into saturation)
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 4'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 16'($urandom),
                 3'($urandom));
        end
        chk("opc_saturated", {26'd0, op_count}, (1 << CNTW) - 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the 16-bit carry-ripple ALU. Captures the ALU result Y, the 16-bit flags word and the 4-bit op select.
- Buffers them in a 2-entry skid queue with valid/ready handshakes on both sides.
- Maintains the architectural processor status register (PSR), with per-op flag update masks.
- Provides PSR-based condition evaluation for the branch/writeback logic.

Parameters:
- BITSIZE, 16, datapath width; must match the ALU BITSIZE.
- DEPTH, 2, queue entries; only 2 is supported.
- CNTW, 16, width of the accepted-op statistics counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU output is valid this cycle.
- in_ready  output  1  stage can accept; registered.
- in_y  input  BITSIZE  ALU result Y.
- in_flags  input  16  ALU flags word: bit0 C, bit2 L, bit5 F (overflow), bit6 Z, bit7 N.
- in_sel  input  4  ALU sel used for this result.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry.
- out_y  output  BITSIZE  head result.
- out_flags  output  16  head flags snapshot, exactly as received.
- out_sel  output  4  head op select.
- psr_wr  input  1  explicit PSR load.
- psr_din  input  16  PSR load value.
- psr  output  16  current PSR.
- cond_sel  input  3  condition code selector.
- cond_true  output  1  selected condition evaluated on the current PSR.
- op_count  output  CNTW  count of accepted ops.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - count=0, out_valid=0, in_ready=1, out_y/out_flags/out_sel=0, psr=0x0000, op_count=0.
  - The queue contents are discarded.
  - Reset asserted mid-transfer drops the in-flight entries; no partial PSR update occurs.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - count (0..2) is updated at the clock edge: +1 on push only, -1 on pop only, unchanged on push+pop.
- Ready/valid derivation:
  - in_ready = (count_next < 2), registered. Therefore in_ready=0 whenever count=2, and no push can occur at count=2 even if a pop occurs the same cycle.
  - in_ready returns to 1 on the cycle after a pop from full.
- Latency and ordering:
  - Latency is 1 cycle: an entry pushed at edge t is visible on out_* with out_valid=1 after edge t if the queue was empty.
  - Order is strictly FIFO.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Empty:
  - out_valid=0 and out_* hold their last values.
  - A push+pop is not possible when empty, since out_valid=0.
- PSR update: at push time, in program order, not at pop.
  - Arithmetic ops (in_sel[3:1]==3'b010, add/sub): bits 0, 2, 5, 6, 7 are copied from in_flags.
  - Logic ops (in_sel[3]==1): bits 6, 7 are copied; C, L and F are retained.
  - All other sel values: PSR unchanged.
  - Bits 1, 3, 4 and 15:8 are always 0. These bits are also masked on psr_wr.
  - psr_wr in the same cycle as a push: psr_wr wins and the push's PSR update is discarded. The push itself still enqueues.
- cond_true is combinational from the registered psr:
  - 0: 1
  - 1: Z
  - 2: !Z
  - 3: N
  - 4: C
  - 5: L
  - 6: F
  - 7: !N & !Z
- op_count increments on each push and saturates at all-ones; it never wraps.
- No X propagation: the out_* registers load only on the transitions that change the head entry.

Test Plan:
- Reset release, then push Y=0x8000, flags=0x00A0, sel=0x4 with out_ready=1 → out_valid=1 next cycle, out_y=0x8000; psr=0x00A0; cond_sel=6 → cond_true=1; op_count=1.
- Hold out_ready=0 and push 3 back-to-back → first two accepted, in_ready=0 during the third; count=2. Raise out_ready → entries pop in order, and in_ready=1 one cycle after the first pop.
- Logic op sel=0x8 with flags=0x0041 after psr=0x0025 → psr=0x0065 (C/L/F retained, Z set, bit0 of in_flags ignored); cond_sel=1 → 1.
- psr_wr=1, psr_din=0xFFFF simultaneous with an arithmetic push of flags=0x0000 → psr=0x00E5; the entry is still enqueued.
- With count=1, push+pop for 10 cycles → count stays 1, in_ready=1 throughout; data streams with 1-cycle latency.
- Assert rst_n=0 with count=2 and psr=0x0040 → immediately out_valid=0, psr=0, in_ready=1; op_count=0.
